// File: rtl/gamepad_scan.sv
// rtl/gamepad_scan.sv - serial NES/SNES pad scanner with atomic commit and change detection
//
// Scans 2**SEL_WIDTH groups of DATA_WIDTH shift-register pads, BITS bits each,
// and publishes the decoded buttons to the register bank in a single cycle.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   gp_sel      active group index (binary), holds last group when idle
//   gp_data     pad serial data, active-low, asynchronous to clk
//   gp_latch    pad latch, active-high
//   gp_clk      pad shift clock, idles high
//   gp_value    decoded buttons, 1 = pressed, updated only on commit
//   gp_change   bits that differ between the last two commits
//   gp_changed  1-cycle strobe: the commit changed at least one bit
//   scan_done   1-cycle strobe on every commit
//   busy        high from scan start until the end of the inter-scan gap
//   ctrl_run    level: scan continuously
//   ctrl_trig   pulse: start one scan when idle

module gamepad_scan_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   // Reset to the released (high) line level so nothing reads as pressed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

module gamepad_scan #(
   parameter int DIV        = 15,
   parameter int SEL_WIDTH  = 1,
   parameter int DATA_WIDTH = 2,
   parameter int BITS       = 16,
   parameter int GAP        = 4,
   localparam int VW        = (2 ** SEL_WIDTH) * DATA_WIDTH * BITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [SEL_WIDTH-1:0]  gp_sel,
   input  logic [DATA_WIDTH-1:0] gp_data,
   output logic                  gp_latch,
   output logic                  gp_clk,
   output logic [VW-1:0]         gp_value,
   output logic [VW-1:0]         gp_change,
   output logic                  gp_changed,
   output logic                  scan_done,
   output logic                  busy,
   input  logic                  ctrl_run,
   input  logic                  ctrl_trig
);

   localparam int G        = 2 ** SEL_WIDTH;
   localparam int CW       = $clog2(DIV + 1);
   localparam int BW       = $clog2(BITS);
   localparam int PMAX     = (GAP > 2) ? GAP : 2;
   localparam int PW       = $clog2(PMAX);
   localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEL,
      S_LATCH,
      S_HOLD,
      S_CLK_LO,
      S_CLK_HI,
      S_COMMIT,
      S_GAP
   } state_t;

   state_t                  state;
   logic [CW-1:0]           div_cnt;
   logic                    tick;
   logic [PW-1:0]           per_cnt;
   logic [BW-1:0]           bit_cnt;
   logic [SEL_WIDTH-1:0]    grp;
   logic [DATA_WIDTH-1:0]   data_sync;
   logic                    sample_en;
   logic [VW-1:0]           staging;

   gamepad_scan_sync #(
      .W (DATA_WIDTH)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (gp_data),
      .q     (data_sync)
   );

   assign tick = (div_cnt == CW'(DIV));

   // Bits are taken on the last cycle of HOLD (bit 0) and of each CLK_HI,
   // giving the synchronizer a full half-period to settle after the edge.
   assign sample_en = tick && ((state == S_HOLD) || (state == S_CLK_HI));

   // One shift register per data line and group. Bit 0 arrives first and is
   // shifted in at the top, so after BITS samples it sits at the LSB and the
   // flat layout is staging[(g*DATA_WIDTH+d)*BITS + b].
   generate
      for (genvar d = 0; d < DATA_WIDTH; d++) begin : g_line
         logic [G-1:0][BITS-1:0] sr;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sr <= '0;
            end else if (sample_en) begin
               sr[grp] <= {~data_sync[d], sr[grp][BITS-1:1]};
            end
         end

         for (genvar g = 0; g < G; g++) begin : g_grp
            assign staging[(g * DATA_WIDTH + d) * BITS +: BITS] = sr[g];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         div_cnt    <= '0;
         per_cnt    <= '0;
         bit_cnt    <= '0;
         grp        <= '0;
         gp_sel     <= '0;
         gp_latch   <= 1'b0;
         gp_clk     <= 1'b1;
         gp_value   <= '0;
         gp_change  <= '0;
         gp_changed <= 1'b0;
         scan_done  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         scan_done  <= 1'b0;
         gp_changed <= 1'b0;

         // The divider rests at zero in IDLE and COMMIT so every timed state
         // starts on a fresh half-bit period.
         if ((state == S_IDLE) || (state == S_COMMIT) || tick) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (ctrl_run || ctrl_trig) begin
                  state  <= S_SEL;
                  grp    <= '0;
                  gp_sel <= '0;
                  busy   <= 1'b1;
               end
            end

            S_SEL: begin
               if (tick) begin
                  state    <= S_LATCH;
                  gp_latch <= 1'b1;
                  per_cnt  <= '0;
               end
            end

            S_LATCH: begin
               if (tick) begin
                  if (per_cnt == PW'(1)) begin
                     state    <= S_HOLD;
                     gp_latch <= 1'b0;
                  end else begin
                     per_cnt <= per_cnt + 1'b1;
                  end
               end
            end

            S_HOLD: begin
               if (tick) begin
                  state   <= S_CLK_LO;
                  gp_clk  <= 1'b0;
                  bit_cnt <= BW'(1);
               end
            end

            S_CLK_LO: begin
               if (tick) begin
                  state  <= S_CLK_HI;
                  gp_clk <= 1'b1;
               end
            end

            S_CLK_HI: begin
               if (tick) begin
                  if (bit_cnt == BW'(BITS - 1)) begin
                     if (grp == SEL_WIDTH'(G - 1)) begin
                        state <= S_COMMIT;
                     end else begin
                        grp    <= grp + 1'b1;
                        gp_sel <= grp + 1'b1;
                        state  <= S_SEL;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     gp_clk  <= 1'b0;
                     state   <= S_CLK_LO;
                  end
               end
            end

            // The whole scan becomes visible at once; the change mask and
            // strobes are derived from the value being replaced.
            S_COMMIT: begin
               gp_value   <= staging;
               gp_change  <= gp_value ^ staging;
               gp_changed <= (gp_value != staging);
               scan_done  <= 1'b1;
               per_cnt    <= '0;
               if (GAP > 0) begin
                  state <= S_GAP;
               end else if (ctrl_run) begin
                  state  <= S_SEL;
                  grp    <= '0;
                  gp_sel <= '0;
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end

            // Continuous scanning restarts straight from the gap so the scan
            // period has no idle cycle in it; a trigger here is not queued.
            S_GAP: begin
               if (tick) begin
                  if (per_cnt == PW'(GAP_LAST)) begin
                     if (ctrl_run) begin
                        state  <= S_SEL;
                        grp    <= '0;
                        gp_sel <= '0;
                     end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     per_cnt <= per_cnt + 1'b1;
                  end
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gamepad_scan.sv
// tb/tb_gamepad_scan.sv - randomized model-checked bench for gamepad_scan
module tb_gamepad_scan;

   localparam int DIV    = 3;
   localparam int SEL_W  = 1;
   localparam int DW     = 2;
   localparam int BITS   = 16;
   localparam int GAP    = 4;
   localparam int T      = DIV + 1;
   localparam int G      = 1 << SEL_W;
   localparam int VW     = G * DW * BITS;
   localparam int GRP    = (2 * BITS + 2) * T;
   localparam int SCANC  = G * GRP;
   localparam int SCAN   = SCANC + 1;
   localparam int PERIOD = SCAN + GAP * T;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [SEL_W-1:0] gp_sel;
   logic [DW-1:0]    gp_data;
   logic             gp_latch, gp_clk;
   logic [VW-1:0]    gp_value, gp_change;
   logic             gp_changed, scan_done, busy;
   logic             ctrl_run = 1'b0;
   logic             ctrl_trig = 1'b0;

   always #5 clk = ~clk;

   gamepad_scan #(
      .DIV        (DIV),
      .SEL_WIDTH  (SEL_W),
      .DATA_WIDTH (DW),
      .BITS       (BITS),
      .GAP        (GAP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .gp_sel     (gp_sel),
      .gp_data    (gp_data),
      .gp_latch   (gp_latch),
      .gp_clk     (gp_clk),
      .gp_value   (gp_value),
      .gp_change  (gp_change),
      .gp_changed (gp_changed),
      .scan_done  (scan_done),
      .busy       (busy),
      .ctrl_run   (ctrl_run),
      .ctrl_trig  (ctrl_trig)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Pad model: buttons (1 = pressed) load on latch, advance on gp_clk rise.
   logic [VW-1:0] btn_flat = '1;
   int            pad_idx = 0;
   logic          prev_gclk = 1'b1;

   always @(posedge clk) begin
      prev_gclk <= gp_clk;
      if (gp_latch) pad_idx <= 0;
      else if (gp_clk && !prev_gclk) pad_idx <= pad_idx + 1;
   end

   always_comb begin
      gp_data = '0;
      for (int d = 0; d < DW; d++)
         if (pad_idx < BITS) gp_data[d] = ~btn_flat[(int'(gp_sel) * DW + d) * BITS + pad_idx];
   end

   // Reference: a scan is a position counter from its start; the waveform and
   // commit follow from the position by arithmetic.
   logic          m_active;
   int            m_pos;
   logic [VW-1:0] m_value, m_change;
   logic          m_done, m_chg;
   logic [SEL_W-1:0] m_sel;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0; m_pos <= 0; m_value <= '0; m_change <= '0;
         m_done <= 1'b0; m_chg <= 1'b0; m_sel <= '0;
      end else if (!m_active) begin
         m_done <= 1'b0; m_chg <= 1'b0;
         if (ctrl_run || ctrl_trig) begin
            m_active <= 1'b1; m_pos <= 0; m_sel <= '0;
         end
      end else begin
         if (m_pos + 1 == SCAN) begin
            m_done <= 1'b1; m_chg <= (m_value != btn_flat);
            m_value <= btn_flat; m_change <= m_value ^ btn_flat;
         end else begin
            m_done <= 1'b0; m_chg <= 1'b0;
         end
         if (m_pos + 1 == PERIOD) begin
            m_pos <= 0; m_active <= ctrl_run;
            if (ctrl_run) m_sel <= '0;
         end else begin
            m_pos <= m_pos + 1;
            if (m_pos + 1 < SCANC) m_sel <= SEL_W'((m_pos + 1) / GRP);
         end
      end
   end

   function automatic logic exp_latch(input logic act, input int pos);
      int off;
      if (!act || pos >= SCANC) return 1'b0;
      off = pos % GRP;
      return (off >= T) && (off < 3 * T);
   endfunction

   function automatic logic exp_gclk(input logic act, input int pos);
      int off;
      if (!act || pos >= SCANC) return 1'b1;
      off = pos % GRP;
      if (off < 4 * T) return 1'b1;
      return (((off - 4 * T) / T) % 2) != 0;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         chk("value", gp_value, m_value);
         chk("change", gp_change, m_change);
         chk("scan_done", 64'(scan_done), 64'(m_done));
         chk("gp_changed", 64'(gp_changed), 64'(m_chg));
         chk("busy", 64'(busy), 64'(m_active));
         chk("gp_sel", 64'(gp_sel), 64'(m_sel));
         chk("gp_latch", 64'(gp_latch), 64'(exp_latch(m_active, m_pos)));
         chk("gp_clk", 64'(gp_clk), 64'(exp_gclk(m_active, m_pos)));
      end
   end

   int lat_cycles = 0, clklo_cycles = 0, done_cnt = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (rst_n) begin
         if (gp_latch) lat_cycles <= lat_cycles + 1;
         if (!gp_clk) clklo_cycles <= clklo_cycles + 1;
         if (scan_done) done_cnt <= done_cnt + 1;
      end
   end

   task automatic pulse_trig();
      @(negedge clk); ctrl_trig = 1'b1;
      @(negedge clk); ctrl_trig = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      @(negedge clk);
      while (!scan_done && n < 2000) begin @(negedge clk); n++; end
      checks++;
      if (!scan_done) begin errors++; $display("FAIL %s scan_done timeout actual=0 required=1", name); end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while (busy && n < 2000) begin @(negedge clk); n++; end
      checks++;
      if (busy) begin errors++; $display("FAIL %s busy timeout actual=1 required=0", name); end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_sel"}, 64'(gp_sel), 64'd0);
      chk({tag, "_latch"}, 64'(gp_latch), 64'd0);
      chk({tag, "_gclk"}, 64'(gp_clk), 64'd1);
      chk({tag, "_value"}, gp_value, 64'd0);
      chk({tag, "_change"}, gp_change, 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(scan_done), 64'd0);
      chk({tag, "_changed"}, 64'(gp_changed), 64'd0);
   endtask

   initial begin
      int l0, c0, d0, t1, t2, k, n;
      logic [VW-1:0] one_hot;

      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      #1 rst_n = 1'b1;

      repeat (1000) @(negedge clk);
      chk("idle_latch", 64'(gp_latch), 64'd0);
      chk("idle_gclk", 64'(gp_clk), 64'd1);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_value", gp_value, 64'd0);

      // Single trigger, every button pressed.
      btn_flat = '1; l0 = lat_cycles; c0 = clklo_cycles;
      pulse_trig();
      wait_done("trig1");
      chk("trig1_value", gp_value, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("trig1_changed", 64'(gp_changed), 64'd1);
      chk("trig1_change", gp_change, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("trig1_latch_cycles", 64'(lat_cycles - l0), 64'd16);
      chk("trig1_clklo_cycles", 64'(clklo_cycles - c0), 64'd120);
      wait_idle("trig1");

      // Group 0 line 1 carries 0xA5C3.
      btn_flat = 64'hFFFF_FFFF_A5C3_FFFF;
      pulse_trig();
      wait_done("a5c3");
      chk("a5c3_value", gp_value, 64'hFFFF_FFFF_A5C3_FFFF);
      chk("a5c3_change", gp_change, 64'h0000_0000_5A3C_0000);
      wait_idle("a5c3");

      // Continuous scanning with static pads.
      btn_flat = ~btn_flat;
      @(negedge clk); ctrl_run = 1'b1;
      wait_done("run1"); t1 = cyc;
      chk("run1_changed", 64'(gp_changed), 64'd1);
      wait_done("run2"); t2 = cyc;
      chk("run_period1", 64'(t2 - t1), 64'd289);
      chk("run2_changed", 64'(gp_changed), 64'd0);
      chk("run2_change", gp_change, 64'd0);
      wait_done("run3"); t1 = cyc;
      chk("run_period2", 64'(t1 - t2), 64'd289);
      chk("run3_changed", 64'(gp_changed), 64'd0);

      // Single bit flips between scans.
      repeat (4) begin
         k = $urandom_range(0, VW - 1);
         btn_flat[k] = ~btn_flat[k];
         one_hot = '0; one_hot[k] = 1'b1;
         wait_done("toggle");
         chk("toggle_change", gp_change, one_hot);
         chk("toggle_changed", 64'(gp_changed), 64'd1);
      end

      // Drop run mid-scan: that scan still commits.
      repeat (50) @(negedge clk);
      ctrl_run = 1'b0;
      wait_done("drop");
      wait_idle("drop");
      repeat (20) @(negedge clk);
      chk("drop_stays_idle", 64'(busy), 64'd0);

      // Randomized mix of triggers (ignored while busy) and short runs.
      for (int it = 0; it < 6; it++) begin
         btn_flat = {$urandom(), $urandom()};
         d0 = done_cnt;
         if (it % 2 == 1) begin
            @(negedge clk); ctrl_run = 1'b1; ctrl_trig = 1'b1;
            @(negedge clk); ctrl_trig = 1'b0;
            wait_done("rand_run_a");
            btn_flat = {$urandom(), $urandom()};
            wait_done("rand_run_b");
            ctrl_run = 1'b0;
            wait_idle("rand_run");
            repeat (2) @(negedge clk);
            chk("rand_run_scans", 64'(done_cnt - d0), 64'd2);
         end else begin
            pulse_trig();
            repeat ($urandom_range(1, 4)) begin
               repeat ($urandom_range(5, 60)) @(negedge clk);
               pulse_trig();
            end
            wait_idle("rand_trig");
            repeat (2) @(negedge clk);
            chk("rand_trig_scans", 64'(done_cnt - d0), 64'd1);
            chk("rand_trig_value", gp_value, btn_flat);
         end
      end

      // Reset during CLK_LO of group 1.
      btn_flat = {$urandom(), $urandom()};
      pulse_trig();
      n = 0;
      while (!(gp_sel == 1 && gp_clk == 1'b0) && n < 2000) begin @(negedge clk); n++; end
      chk("midrst_reached", 64'(gp_sel == 1 && gp_clk == 1'b0), 64'd1);
      #1 rst_n = 1'b0;
      #1 chk_reset_vals("midrst");
      @(negedge clk);
      #1 rst_n = 1'b1;
      pulse_trig();
      wait_done("post_rst");
      chk("post_rst_value", gp_value, btn_flat);
      chk("post_rst_changed", 64'(gp_changed), 64'(btn_flat != '0));
      wait_idle("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gamepad_scan.md
Name: gamepad_scan

Overview:
- Next-generation serial gamepad controller for NES/SNES-style shift-register pads.
- Scans 2^SEL_WIDTH pad groups, each with DATA_WIDTH parallel data lines, BITS bits per pad. Groups are selected with a binary-encoded gp_sel.
- Adds single-shot triggering, an inter-scan gap, an atomic value commit, and change detection with a per-bit change mask.
- Sits between board pad pins and the CPU-visible register bank.

Parameters:
- DIV, 15, divider; one half-bit period T = DIV+1 clk cycles; must be >= 2.
- SEL_WIDTH, 1, gp_sel width; number of groups G = 2^SEL_WIDTH.
- DATA_WIDTH, 2, data lines (pads) per group.
- BITS, 16, bits shifted per pad (8 = NES, 16 = SNES); must be >= 2.
- GAP, 4, idle periods T between consecutive continuous scans.
- VW, G*DATA_WIDTH*BITS, gp_value width (64 at defaults).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- gp_sel  out  SEL_WIDTH  active group index
- gp_data  in  DATA_WIDTH  pad serial data, active-low, asynchronous
- gp_latch  out  1  pad latch, active-high
- gp_clk  out  1  pad shift clock, idles high
- gp_value  out  VW  decoded buttons, 1 = pressed
- gp_change  out  VW  bits that differ between the last two commits
- gp_changed  out  1  1-cycle strobe: a commit changed at least one bit
- scan_done  out  1  1-cycle strobe on every commit
- busy  out  1  high from scan start until the end of GAP
- ctrl_run  in  1  level: continuous scanning
- ctrl_trig  in  1  pulse: one scan when idle

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - gp_sel=0, gp_latch=0, gp_clk=1, gp_value=0, gp_change=0.
  - gp_changed=0, scan_done=0, busy=0.
  - FSM=IDLE, divider=0.
- gp_data passes through a 2-FF synchronizer; all sampling uses the synchronized value.
- Divider counts 0..DIV and emits a tick at DIV. It is cleared on leaving IDLE. Each state below lasts 1 T unless noted.
- FSM:
  - IDLE: leaves to SEL (g=0) when ctrl_run=1 or ctrl_trig=1. busy goes high the cycle after start.
  - SEL: gp_sel=g.
  - LATCH: gp_latch=1 for 2 T.
  - HOLD: gp_latch=0. On the final cycle, sample bit 0 of every data line.
  - CLK_LO: gp_clk=0.
  - CLK_HI: gp_clk=1. On the final cycle, sample bit b. Loop CLK_LO/CLK_HI until bit BITS-1 is sampled.
  - After the last bit: if g<G-1, then g++ and go to SEL. Otherwise COMMIT (1 clk), then GAP (GAP*T), then IDLE.
- Mapping: staging[(g*DATA_WIDTH+d)*BITS+b] = ~data_sync[d].
- Scan length: G*(2*BITS+2)*T + 1 clk; 68*T+1 at defaults.
- COMMIT, all in the same cycle:
  - gp_value <= staging.
  - gp_change <= gp_value ^ staging.
  - scan_done=1.
  - gp_changed = (gp_value != staging).
- gp_value never shows a partial scan.
- ctrl_run=1 at GAP end: the next scan starts immediately with no extra IDLE cycle.
- ctrl_run dropped mid-scan: the current scan completes and commits, then IDLE.
- ctrl_trig while busy: ignored, not queued.
- ctrl_trig and ctrl_run both high: one start.
- gp_sel holds the last group value in IDLE and GAP.
- gp_latch and gp_clk are never both active. gp_clk is high whenever gp_latch=1.
- rst_n asserted mid-scan: immediate return to reset values, staging discarded.

Test Plan:
- Reset then ctrl_run=0, no trig → gp_latch=0, gp_clk=1, busy=0, gp_value=0 for 1000 cycles.
- DIV=3, all gp_data held 0, one ctrl_trig pulse:
  - gp_latch high for exactly 8 clk.
  - 15 low pulses of gp_clk, 4 clk each, per group.
  - scan_done one pulse; gp_value=all ones; gp_changed=1; gp_change=all ones.
  - busy returns to 0 after the gap.
- Pad model shifts 0xA5C3 (group 0, line 1, active-low, bit 0 first) and zeros elsewhere → gp_value[31:16]=0xA5C3; all other bits 1.
- ctrl_run=1, pads static for 3 scans:
  - scan_done every 68*T+1+GAP*T clk.
  - gp_changed only on the first scan; gp_change=0 afterwards.
- Toggle one pad bit between scans → gp_changed=1; gp_change has exactly that single bit set.
- rst_n low during CLK_LO of group 1 → outputs at reset values the same cycle; next scan gives a full, correct value.
